// File: rtl/clap_pkg.sv
// Shared types and constants for the clap counter and its toggle-light consumer.
package clap_pkg;
    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_COUNTING = 2'd1,
        ST_OUTPUT   = 2'd2
    } clap_state_e;

    localparam int SUC_CLAPS_WIDTH_DEF = 16;

    // Clap counts the consumer maps to light on / light off.
    localparam int TOGLITE_ON_VAL  = 1;
    localparam int TOGLITE_OFF_VAL = 2;
endpackage

// File: rtl/clap_edge_detect.sv
// Rising-edge pulse from the clap detector level.
// CLAP_COUNTER_SYNC_EN adds a 2-flop synchronizer in front (edge appears 2 cycles after pin rise).
module clap_edge_detect (
    input  logic clock,
    input  logic nreset,
    input  logic clap_det_i,
    output logic clap_edge_o
);
    logic lvl;
    logic lvl_q;

`ifdef CLAP_COUNTER_SYNC_EN
    logic [1:0] sync_q;

    always_ff @(posedge clock) begin
        if (!nreset) sync_q <= '0;
        else         sync_q <= {sync_q[0], clap_det_i};
    end

    assign lvl = sync_q[1];
`else
    assign lvl = clap_det_i;
`endif

    always_ff @(posedge clock) begin
        if (!nreset) lvl_q <= 1'b0;
        else         lvl_q <= lvl;
    end

    assign clap_edge_o = lvl & ~lvl_q;
endmodule

// File: rtl/clap_counter.sv
// Groups debounced claps inside a silence window and emits the group size on a valid/ready stream.
// Define CLAP_COUNTER_SYNC_EN when clap_det is asynchronous to clock.
module clap_counter
    import clap_pkg::*;
#(
    parameter int SUC_CLAPS_WIDTH    = SUC_CLAPS_WIDTH_DEF,
    parameter int TIMER_WIDTH        = 26,
    parameter int CLAP_GAP_CYCLES    = 5000000,
    parameter int CLAP_WINDOW_CYCLES = 50000000
) (
    input  logic                       clock,
    input  logic                       nreset,
    input  logic                       clap_det,
    output logic [SUC_CLAPS_WIDTH-1:0] suc_claps_data,
    output logic                       suc_claps_valid,
    input  logic                       suc_claps_ready
);
    localparam logic [TIMER_WIDTH-1:0]     GAP_M1  = TIMER_WIDTH'(CLAP_GAP_CYCLES - 1);
    localparam logic [TIMER_WIDTH-1:0]     WIN_M1  = TIMER_WIDTH'(CLAP_WINDOW_CYCLES - 1);
    localparam logic [SUC_CLAPS_WIDTH-1:0] CNT_MAX = '1;

    clap_state_e                state_q;
    logic [SUC_CLAPS_WIDTH-1:0] count_q;
    logic [SUC_CLAPS_WIDTH-1:0] count_d;
    logic [TIMER_WIDTH-1:0]     timer_q;
    logic [TIMER_WIDTH-1:0]     timer_d;
    logic [SUC_CLAPS_WIDTH-1:0] data_q;
    logic                       valid_q;
    logic                       clap_edge;

    clap_edge_detect u_edge (
        .clock       (clock),
        .nreset      (nreset),
        .clap_det_i  (clap_det),
        .clap_edge_o (clap_edge)
    );

    // Saturating increment keeps a long burst from wrapping back to a small count.
    assign count_d = (count_q == CNT_MAX) ? count_q : count_q + 1'b1;
    assign timer_d = timer_q + 1'b1;

    always_ff @(posedge clock) begin
        if (!nreset) begin
            state_q <= ST_IDLE;
            count_q <= '0;
            timer_q <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (clap_edge) begin
                        count_q <= SUC_CLAPS_WIDTH'(1);
                        timer_q <= '0;
                        state_q <= ST_COUNTING;
                    end
                end
                ST_COUNTING: begin
                    // An accepted clap on the expiry cycle keeps the group open.
                    if (clap_edge && timer_q >= GAP_M1) begin
                        count_q <= count_d;
                        timer_q <= '0;
                    end else if (timer_q == WIN_M1) begin
                        data_q  <= count_q;
                        valid_q <= 1'b1;
                        state_q <= ST_OUTPUT;
                    end else begin
                        timer_q <= timer_d;
                    end
                end
                ST_OUTPUT: begin
                    if (suc_claps_ready) begin
                        valid_q <= 1'b0;
                        count_q <= '0;
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign suc_claps_data  = data_q;
    assign suc_claps_valid = valid_q;
endmodule

// File: tb/tb_clap_counter.sv
// Bench for clap_counter: vector table, multi-cycle corner sequences and random stimulus vs a timestamp model.
module tb_clap_counter;
    localparam int W    = 16;
    localparam int SW   = 2;
    localparam int TW   = 26;
    localparam int GAP  = 4;
    localparam int WIN  = 20;
    localparam int MAXC = (1 << W) - 1;
`ifdef CLAP_COUNTER_SYNC_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 0;
`endif
    localparam int NC = 8192;

    logic          clock = 1'b0;
    logic          nreset = 1'b0;
    logic          clap_det = 1'b0;
    logic          ready = 1'b1;
    logic          det2 = 1'b0;
    logic          ready2 = 1'b1;
    logic [W-1:0]  data;
    logic          valid;
    logic [SW-1:0] data2;
    logic          valid2;

    always #5 clock = ~clock;

    clap_counter #(.SUC_CLAPS_WIDTH(W), .TIMER_WIDTH(TW), .CLAP_GAP_CYCLES(GAP),
                   .CLAP_WINDOW_CYCLES(WIN)) dut (
        .clock(clock), .nreset(nreset), .clap_det(clap_det),
        .suc_claps_data(data), .suc_claps_valid(valid), .suc_claps_ready(ready));

    clap_counter #(.SUC_CLAPS_WIDTH(SW), .TIMER_WIDTH(TW), .CLAP_GAP_CYCLES(GAP),
                   .CLAP_WINDOW_CYCLES(WIN)) dut_sat (
        .clock(clock), .nreset(nreset), .clap_det(det2),
        .suc_claps_data(data2), .suc_claps_valid(valid2), .suc_claps_ready(ready2));

    int total = 0;
    int bad   = 0;

    // Reference model: groups tracked by the timestamp of the last accepted clap.
    logic det_hist[NC];
    int   cyc = 0;
    int   bnd = 0;      // first cycle whose pin value survives the latest reset
    int   m_mode = 0;   // 0 idle, 1 group open, 2 count offered
    int   m_last = 0;
    int   m_cnt = 0;
    int   m_emit = 0;

    logic          obs_v, obs_v2;
    logic [W-1:0]  obs_d;
    logic [SW-1:0] obs_d2;

    function automatic logic lvl_at(int t);
        if (t - LAT < 0 || t - LAT < bnd) return 1'b0;
        return det_hist[(t - LAT) % NC];
    endfunction

    function automatic logic [63:0] bits(int lo, int hi);
        logic [63:0] one = 64'd1;
        return (one << (hi + 1)) - (one << lo);
    endfunction

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // One clock cycle: inputs already driven; sample and model at negedge.
    task automatic tick();
        logic e;
        @(negedge clock);
        det_hist[cyc % NC] = clap_det;
        e = lvl_at(cyc) & ~lvl_at(cyc - 1);
        chk("model_valid", {63'd0, valid}, (m_mode == 2) ? 64'd1 : 64'd0);
        chk("model_data", {48'd0, data}, 64'(m_emit));
        obs_v = valid; obs_d = data; obs_v2 = valid2; obs_d2 = data2;
        if (!nreset) begin
            m_mode = 0; m_emit = 0; bnd = cyc + 1;
        end else begin
            case (m_mode)
                0: if (e) begin m_mode = 1; m_last = cyc; m_cnt = 1; end
                1: begin
                    if (e && (cyc - m_last) >= GAP) begin
                        m_cnt = (m_cnt == MAXC) ? MAXC : m_cnt + 1;
                        m_last = cyc;
                    end else if (cyc - m_last == WIN) begin
                        m_mode = 2; m_emit = m_cnt;
                    end
                end
                default: if (ready) m_mode = 0;
            endcase
        end
        cyc++;
        @(posedge clock);
        #1;
    endtask

    typedef struct {
        logic [63:0] pat;
        int          exp_at;
        int          exp_data;
        int          exp_n;
    } vec_t;

    vec_t vt[8];

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int first, fd, n, hold_ok, v2n, v2at, v2d;

        vt[0] = '{bits(10, 12),                                31, 1, 1};
        vt[1] = '{bits(10, 12) | bits(18, 20),                 39, 2, 1};
        vt[2] = '{bits(10, 10) | bits(12, 13) | bits(18, 20),  39, 2, 1};
        vt[3] = '{bits(10, 11) | bits(14, 15),                 35, 2, 1};
        vt[4] = '{bits(10, 11) | bits(13, 14),                 31, 1, 1};
        vt[5] = '{bits(10, 11) | bits(30, 31),                 51, 2, 1};
        vt[6] = '{bits(10, 11) | bits(31, 32),                 31, 1, 1};
        vt[7] = '{bits(10, 11) | bits(32, 33),                 31, 1, 2};

        repeat (3) @(posedge clock);
        #1;
        chk("rst_valid", {63'd0, valid}, 64'd0);
        chk("rst_data", {48'd0, data}, 64'd0);
        chk("rst_valid_sat", {63'd0, valid2}, 64'd0);
        chk("rst_data_sat", {62'd0, data2}, 64'd0);
        nreset = 1'b1;

        for (int i = 0; i < 8; i++) begin
            first = -1; fd = 0; n = 0;
            for (int rel = 0; rel < 100; rel++) begin
                clap_det = (rel < 64) ? vt[i].pat[rel] : 1'b0;
                tick();
                if (obs_v) begin
                    n++;
                    if (first < 0) begin first = rel; fd = int'(obs_d); end
                end
            end
            chk($sformatf("vec%0d_at", i), 64'(first), 64'(vt[i].exp_at + LAT));
            chk($sformatf("vec%0d_data", i), 64'(fd), 64'(vt[i].exp_data));
            chk($sformatf("vec%0d_pulses", i), 64'(n), 64'(vt[i].exp_n));
        end

        // Back-pressure: count held, clap during hold ignored, next group fresh.
        first = -1; fd = 0; hold_ok = 0; n = -1;
        for (int rel = 0; rel < 141; rel++) begin
            clap_det = rel inside {[10:12], [18:20], [50:52], [100:102]};
            ready = (rel >= 89);
            tick();
            if (rel >= 39 + LAT && rel < 89 && obs_v && obs_d == W'(2)) hold_ok++;
            if (rel == 90) chk("hold_drop", {63'd0, obs_v}, 64'd0);
            if (rel > 90 && obs_v && first < 0) begin first = rel; fd = int'(obs_d); end
            if (rel < 39 + LAT && obs_v) n = rel;
        end
        chk("hold_early", 64'(n), -64'sd1);
        chk("hold_stable", 64'(hold_ok), 64'(50 - LAT));
        chk("fresh_at", 64'(first), 64'(121 + LAT));
        chk("fresh_data", 64'(fd), 64'd1);

        // Reset mid-group discards it.
        first = -1; fd = 0; n = 0;
        for (int rel = 0; rel < 90; rel++) begin
            clap_det = rel inside {[10:12], [18:20], [40:42]};
            nreset = (rel != 25);
            tick();
            if (obs_v && rel < 61 + LAT) n++;
            if (obs_v && first < 0 && rel >= 61 + LAT) begin first = rel; fd = int'(obs_d); end
        end
        nreset = 1'b1;
        chk("rst_group_no_emit", 64'(n), 64'd0);
        chk("rst_new_at", 64'(first), 64'(61 + LAT));
        chk("rst_new_data", 64'(fd), 64'd1);

        // Narrow count saturates.
        clap_det = 1'b0;
        v2n = 0; v2at = -1; v2d = 0;
        for (int rel = 0; rel < 90; rel++) begin
            det2 = rel inside {[10:11], [15:16], [20:21], [25:26], [30:31]};
            tick();
            if (obs_v2) begin
                v2n++;
                if (v2at < 0) begin v2at = rel; v2d = int'(obs_d2); end
            end
        end
        det2 = 1'b0;
        chk("sat_at", 64'(v2at), 64'(51 + LAT));
        chk("sat_data", 64'(v2d), 64'd3);
        chk("sat_pulses", 64'(v2n), 64'd1);

        // Random stimulus against the model.
        for (int k = 0; k < 2000; k++) begin
            if ($urandom_range(0, 4) == 0) clap_det = ~clap_det;
            ready  = ($urandom_range(0, 3) != 0);
            nreset = ($urandom_range(0, 399) != 0);
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/clap_counter.md
Name: clap_counter

Overview:
Upstream stage of the toggle-light consumer. Converts the raw clap-detector level into a count of successive claps grouped inside a time window. Edges are debounced by a minimum gap. When the window expires with no further clap, the block emits one count on a valid/ready stream (suc_claps_data / suc_claps_valid / suc_claps_ready).

Parameters:
SUC_CLAPS_WIDTH, 16, width of emitted count; must match the consumer.
TIMER_WIDTH, 26, width of the inter-clap timer.
CLAP_GAP_CYCLES, 5000000, minimum cycles between accepted claps (100 ms at 50 MHz); must be >= 1.
CLAP_WINDOW_CYCLES, 50000000, cycles of silence after the last accepted clap that close a group; must satisfy CLAP_GAP_CYCLES < CLAP_WINDOW_CYCLES < 2^TIMER_WIDTH.

Ports:
clock  input  1  system clock
nreset  input  1  reset: synchronous, active-low
clap_det  input  1  detector level, 1 = sound above threshold; may be asynchronous
suc_claps_data  output  SUC_CLAPS_WIDTH  number of claps in the completed group
suc_claps_valid  output  1  count is valid
suc_claps_ready  input  1  consumer accepts count

Behaviour:
- Reset (nreset==0 at a clock edge): state=IDLE, count=0, timer=0, suc_claps_valid=0, suc_claps_data=0, edge-detect history=0. Reset mid-group or mid-handshake discards everything with no emission.
- Edge detection:
  - lvl = clap_det (after the optional synchronizer).
  - lvl_d = lvl registered.
  - clap_edge = lvl & ~lvl_d.
- States: IDLE, COUNTING, OUTPUT.
- IDLE:
  - On clap_edge: count=1, timer=0, go to COUNTING.
- COUNTING:
  - Each cycle timer increments by 1.
  - If clap_edge and timer >= CLAP_GAP_CYCLES-1: clap accepted; count = count+1, saturating at all-ones; timer=0.
  - If clap_edge and timer < CLAP_GAP_CYCLES-1: edge ignored (bounce); timer keeps running.
  - Else if timer == CLAP_WINDOW_CYCLES-1: go to OUTPUT; suc_claps_data=count.
  - An accepted edge in the same cycle as window expiry wins: no emission, group continues.
- OUTPUT:
  - suc_claps_valid=1; suc_claps_data held stable until the transfer.
  - On valid && ready: valid=0, count=0, go to IDLE.
  - clap_edge during OUTPUT is ignored, including in the transfer cycle.
- Latency: with the edge pulse in cycle E and no further accepted clap, suc_claps_valid first goes high in cycle E + CLAP_WINDOW_CYCLES + 1.
- Ready held high (the consumer ties it to 1): transfer completes in the first valid cycle, so valid is a 1-cycle pulse. Ready held low: valid and data stay stable indefinitely.
- Width rules:
  - Timer never wraps; the window bound guarantees this.
  - Count compare uses an unsigned, full-width saturating add.

Optional Feature:
CLAP_COUNTER_SYNC_EN
- Defined: clap_det passes through a 2-flop synchronizer (reset to 0) before edge detection. Pin-rise to clap_edge latency = 2 cycles.
- Undefined: clap_det is sampled directly. Pin-rise to clap_edge latency = 0 cycles (edge in the first cycle the pin is seen high). Use only when the detector is already synchronous to clock.

Decomposition:
- Package clap_pkg holds:
  - the state enum (IDLE/COUNTING/OUTPUT);
  - SUC_CLAPS_WIDTH default;
  - the shared TOGLITE_ON_VAL=1 / TOGLITE_OFF_VAL=2 constants for the consumer.
- One sub-module, clap_edge_detect: optional synchronizer plus rising-edge pulse generator.
- Timer, counter and FSM stay in the top module.

Test Plan (CLAP_GAP_CYCLES=4, CLAP_WINDOW_CYCLES=20, sync off, ready=1 unless stated):
1. Single clap_det rise at cycle 10, held 3 cycles -> one valid pulse at cycle 31 with data=1; no other valid.
2. Rises at cycles 10 and 18 -> valid at cycle 39, data=2.
3. Rises at 10, 11-low, 12-high (bounce inside gap), then 18 -> bounce ignored, data=2.
4. Ready=0: two claps -> valid held with data=2 for 50 cycles; ready=1 -> valid drops next cycle; a clap during the hold is not counted; the next group starts fresh.
5. Reset mid-group: claps at 10 and 18, nreset=0 at cycle 25 for 1 cycle -> no valid ever; a new clap at 40 yields data=1 at cycle 61.
6. SUC_CLAPS_WIDTH=2, 5 claps spaced 5 cycles -> data saturates at 3; with CLAP_COUNTER_SYNC_EN defined, case 1 valid moves to cycle 33.
